riscv_4bit_ctrl_fsm: RTL and testbench

Multicycle control sequencer for the 4-bit RISC-V-style processor. It steps each instruction through fetch, decode, execute and write-back, and drives the enable/select strobes for the PC, instruction register, register file and ALU. It handles a ready/request handshake with instruction memory, counts retired instructions, and halts on a HALT opcode or an instruction-count limit. It sits between the processor's datapath and its instruction memory.

---
 rtl/riscv_4bit_ctrl_fsm.sv | 117 +++++++++++
 tb/tb_riscv_4bit_ctrl_fsm.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_4bit_ctrl_fsm.sv
// Multicycle control sequencer for the 4-bit RISC-V-style core.
// Steps fetch/decode/execute/write-back and counts retired instructions.
module riscv_4bit_ctrl_fsm #(
  parameter int MAX_INSTR = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       zero,
  input  logic       imem_ready,
  output logic       imem_req,
  output logic       ir_we,
  output logic       alu_src,
  output logic       alu_sub,
  output logic       rf_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic       busy,
  output logic       done,
  output logic [2:0] state,
  output logic [3:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [31:0] LIM = 32'(MAX_INSTR);

  logic [2:0] state_q, state_d;
  logic [3:0] retired_q;
  logic [3:0] ret_inc;
  logic       done_q;
  logic       retire;
  logic       at_limit;

  assign ret_inc  = retired_q + 4'd1;
  assign at_limit = (LIM != 32'd0) && ({28'd0, ret_inc} == LIM);

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    alu_src  = 1'b0;
    alu_sub  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (op == 2'b11) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (op == 2'b10) begin
          alu_sub = 1'b1;
          pc_we   = 1'b1;
          pc_src  = zero;
          retire  = 1'b1;
        end else begin
          alu_src = op[0];
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase
    if (retire) state_d = at_limit ? S_HALT : S_FETCH;
    // reset wins: no strobe may act on the reset edge
    if (reset) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      alu_src  = 1'b0;
      alu_sub  = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      pc_src   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      retired_q <= 4'd0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == S_HALT);
      if (retire) retired_q <= ret_inc;
    end
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign done    = done_q;
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_riscv_4bit_ctrl_fsm.sv
// Bench for riscv_4bit_ctrl_fsm: three instances (limits 15, 3, 0)
// share one stimulus stream and are checked against an instruction model.
module tb_riscv_4bit_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset, start, zero, imem_ready;
  logic [1:0] op;
  logic [15:0] obs [3];

  int n_chk  = 0;
  int n_pass = 0;
  int m_ret [3];
  bit m_halt [3];
  int lim [3] = '{15, 3, 0};

  typedef struct {
    logic [1:0] op;
    logic       rdy;
    logic       z;
    logic [2:0] st;
    logic [6:0] stb;
    bit         ret;
    bit         hlt;
  } cyc_t;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      localparam int L = (g == 0) ? 15 : (g == 1) ? 3 : 0;
      logic       imem_req, ir_we, alu_src, alu_sub;
      logic       rf_we, pc_we, pc_src, busy, done;
      logic [2:0] state;
      logic [3:0] retired;
      riscv_4bit_ctrl_fsm #(.MAX_INSTR(L)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .zero(zero), .imem_ready(imem_ready),
        .imem_req(imem_req), .ir_we(ir_we), .alu_src(alu_src),
        .alu_sub(alu_sub), .rf_we(rf_we), .pc_we(pc_we),
        .pc_src(pc_src), .busy(busy), .done(done),
        .state(state), .retired(retired)
      );
      assign obs[g] = {state, retired, done, busy, imem_req, ir_we,
                       alu_src, alu_sub, rf_we, pc_we, pc_src};
    end
  endgenerate

  // stb = {imem_req, ir_we, alu_src, alu_sub, rf_we, pc_we, pc_src}
  function automatic logic [15:0] expv(logic [2:0] st, logic [3:0] r,
                                       logic dn, logic [6:0] stb);
    logic bz;
    bz = (st != 3'd0) && (st != 3'd5);
    return {st, r, dn, bz, stb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    imem_ready = 1'($urandom);
    op = 2'($urandom);
    zero = 1'($urandom);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (obs[k][6:0] !== 7'd0)
        $display("FAIL reset_strobes dut%0d: got %b want 0000000", k, obs[k][6:0]);
      else n_pass++;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (obs[k] !== expv(3'd0, 4'd0, 1'b0, 7'd0))
        $display("FAIL reset_state dut%0d: got %h want %h", k, obs[k],
                 expv(3'd0, 4'd0, 1'b0, 7'd0));
      else n_pass++;
      m_ret[k]  = 0;
      m_halt[k] = 1'b0;
    end
    reset = 1'b0;
  endtask

  task automatic start_run();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Expand one instruction into its expected cycles, then play them.
  task automatic do_instr(input logic [1:0] iop, input int w,
                          input logic z, input string name);
    cyc_t q[$];
    cyc_t c;
    logic [15:0] e;
    for (int i = 0; i < w; i++)
      q.push_back('{op:2'($urandom), rdy:1'b0, z:1'($urandom),
                    st:3'd1, stb:7'b1000000, ret:1'b0, hlt:1'b0});
    q.push_back('{op:2'($urandom), rdy:1'b1, z:1'($urandom),
                  st:3'd1, stb:7'b1100000, ret:1'b0, hlt:1'b0});
    q.push_back('{op:iop, rdy:1'($urandom), z:1'($urandom),
                  st:3'd2, stb:7'd0, ret:1'b0, hlt:(iop == 2'b11)});
    if (iop == 2'b10) begin
      q.push_back('{op:iop, rdy:1'($urandom), z:z,
                    st:3'd3, stb:{6'b000101, z}, ret:1'b1, hlt:1'b0});
    end else if (iop != 2'b11) begin
      q.push_back('{op:iop, rdy:1'($urandom), z:z,
                    st:3'd3, stb:{2'b00, iop[0], 4'b0000}, ret:1'b0, hlt:1'b0});
      q.push_back('{op:iop, rdy:1'($urandom), z:z,
                    st:3'd4, stb:7'b0000110, ret:1'b1, hlt:1'b0});
    end
    foreach (q[i]) begin
      c = q[i];
      op = c.op;
      imem_ready = c.rdy;
      zero = c.z;
      start = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
        e = m_halt[k] ? expv(3'd5, 4'(m_ret[k]), 1'b1, 7'd0)
                      : expv(c.st, 4'(m_ret[k]), 1'b0, c.stb);
        n_chk++;
        if (obs[k] !== e)
          $display("FAIL %s cyc%0d dut%0d: got %h want %h", name, i, k, obs[k], e);
        else n_pass++;
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        if (!m_halt[k]) begin
          if (c.ret) begin
            m_ret[k] = (m_ret[k] + 1) % 16;
            if (lim[k] != 0 && m_ret[k] == lim[k]) m_halt[k] = 1'b1;
          end
          if (c.hlt) m_halt[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      op = 2'($urandom);
      zero = 1'($urandom);
      imem_ready = 1'($urandom);
      #1;
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs[k] !== expv(3'd0, 4'd0, 1'b0, 7'd0))
          $display("FAIL idle dut%0d cyc%0d: got %h want %h", k, i, obs[k],
                   expv(3'd0, 4'd0, 1'b0, 7'd0));
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_add();
    start_run();
    do_instr(2'b00, 0, 1'b0, "add");
    imem_ready = 1'b0;
    #1;
    n_chk++;
    if (obs[0] !== expv(3'd1, 4'd1, 1'b0, 7'b1000000))
      $display("FAIL add_after: got %h want %h", obs[0],
               expv(3'd1, 4'd1, 1'b0, 7'b1000000));
    else n_pass++;
  endtask

  task automatic test_stall_beq();
    start_run();
    do_instr(2'b10, 3, 1'b1, "beq_stall");
    imem_ready = 1'b0;
    #1;
    n_chk++;
    if (obs[0] !== expv(3'd1, 4'd1, 1'b0, 7'b1000000))
      $display("FAIL beq_after: got %h want %h", obs[0],
               expv(3'd1, 4'd1, 1'b0, 7'b1000000));
    else n_pass++;
  endtask

  task automatic test_halt();
    start_run();
    do_instr(2'b01, 0, 1'b0, "halt_addi");
    do_instr(2'b11, 1, 1'b0, "halt_op");
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom);
      imem_ready = 1'($urandom);
      op = 2'($urandom);
      #1;
      n_chk++;
      if (obs[0] !== expv(3'd5, 4'd1, 1'b1, 7'd0))
        $display("FAIL halt_hold cyc%0d: got %h want %h", i, obs[0],
                 expv(3'd5, 4'd1, 1'b1, 7'd0));
      else n_pass++;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_retire_limit();
    start_run();
    do_instr(2'b00, 0, 1'b0, "lim_add");
    do_instr(2'b10, 1, 1'b0, "lim_beq");
    do_instr(2'b01, 0, 1'b0, "lim_addi");
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'b1;
      start = 1'($urandom);
      #1;
      n_chk++;
      if (obs[1] !== expv(3'd5, 4'd3, 1'b1, 7'd0))
        $display("FAIL lim_halt cyc%0d: got %h want %h", i, obs[1],
                 expv(3'd5, 4'd3, 1'b1, 7'd0));
      else n_pass++;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    start_run();
    do_instr(2'b00, 0, 1'b0, "rst_add");
    imem_ready = 1'b1;
    reset = 1'b1;
    #1;
    n_chk++;
    if (obs[0][6:0] !== 7'd0)
      $display("FAIL rst_mid_strobes: got %b want 0000000", obs[0][6:0]);
    else n_pass++;
    tick();
    reset = 1'b0;
    imem_ready = 1'b0;
    #1;
    n_chk++;
    if (obs[0] !== expv(3'd0, 4'd0, 1'b0, 7'd0))
      $display("FAIL rst_mid_state: got %h want %h", obs[0],
               expv(3'd0, 4'd0, 1'b0, 7'd0));
    else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] rop;
    for (int run = 0; run < 4; run++) begin
      start_run();
      for (int n = 0; n < 20; n++) begin
        rop = 2'($urandom_range(0, 2));
        if (run != 0 && $urandom_range(0, 9) == 0) rop = 2'b11;
        do_instr(rop, $urandom_range(0, 3), 1'($urandom), "rand");
        if (m_halt[0] && m_halt[1] && m_halt[2]) break;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op = 2'b00;
    zero = 1'b0;
    imem_ready = 1'b0;
    test_reset();
    test_add();
    test_stall_beq();
    test_halt();
    test_retire_limit();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
